// File: rtl/control_multiplicador_pkg.sv
// Shared definitions for the shift-and-add multiplier controller.
package mult_pkg;

   localparam int WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/control_multiplicador_if.sv
// Front-panel handshake: operands and start in, busy/done/product out.
interface control_multiplicador_if
   import mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);

   logic               start;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] product;

   modport master (
      output start, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, a, b,
      output busy, done, product
   );

endinterface

// File: rtl/control_multiplicador_sumador_nbits.sv
// Ripple-carry adder built from a chain of full-adder cells.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

module sumador_nbits
   import mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   logic [WIDTH:0] carry;

   assign carry[0] = cin;
   assign cout     = carry[WIDTH];

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (carry[i]),
         .s    (s[i]),
         .cout (carry[i+1])
      );
   end

endmodule

// File: rtl/control_multiplicador.sv
// Sequential shift-and-add unsigned multiplier: one shared adder, WIDTH steps.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one add-and-shift step per edge, WIDTH steps in total
// DONE  | product just loaded; one-cycle done pulse, then back to IDLE
module control_multiplicador
   import mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input logic                     clk,
   input logic                     rst,
   control_multiplicador_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   m_reg;
   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH-1:0]   q_reg;
   logic [CNT_W-1:0]   count;
   logic [2*WIDTH-1:0] product_reg;

   logic [WIDTH-1:0]   addend;
   logic [WIDTH-1:0]   sum;
   logic               cout;
   logic               last_step;
   logic [2*WIDTH-1:0] shifted;

   assign addend    = q_reg[0] ? m_reg : '0;
   assign last_step = (count == CNT_W'(WIDTH - 1));
   // Carry lands in the top bit of the high half, so nothing is ever lost.
   assign shifted   = {cout, sum, q_reg[WIDTH-1:1]};

   sumador_nbits #(.WIDTH(WIDTH)) u_sumador (
      .a    (acc_hi),
      .b    (addend),
      .cin  (1'b0),
      .s    (sum),
      .cout (cout)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode; unused encodings fall back to IDLE.
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = bus.start ? RUN : IDLE;
         RUN:     state_nxt = last_step ? DONE : RUN;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, add-and-shift steps, and product load on the last step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_reg       <= '0;
         acc_hi      <= '0;
         q_reg       <= '0;
         count       <= '0;
         product_reg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  m_reg  <= bus.a;
                  q_reg  <= bus.b;
                  acc_hi <= '0;
                  count  <= '0;
               end
            end
            RUN: begin
               {acc_hi, q_reg} <= shifted;
               count           <= count + 1'b1;
               if (last_step) product_reg <= shifted;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy    = (state == RUN) || (state == DONE);
   assign bus.done    = (state == DONE);
   assign bus.product = product_reg;

endmodule

// File: tb/tb_control_multiplicador.sv
// Randomized self-checking bench for the shift-and-add multiplier controller.
module tb_control_multiplicador;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int vectors     = 0;
   int miscompares = 0;

   control_multiplicador_if #(.WIDTH(W)) bus ();

   control_multiplicador #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int unsigned act, input int unsigned exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // One operation from IDLE; optional start pulse during RUN must be ignored.
   // Expected result and timing come from the arithmetic definition: a*b, done W edges after accept.
   task automatic run_op(input int unsigned op_a, input int unsigned op_b, input bit poke);
      int unsigned exp_p;
      exp_p = op_a * op_b;
      bus.start = 1'b1;
      bus.a     = W'(op_a);
      bus.b     = W'(op_b);
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      check_val("busy_e0", 32'(bus.busy), 1);
      check_val("done_e0", 32'(bus.done), 0);
      for (int k = 1; k <= W; k++) begin
         if (poke && k == 1) begin
            bus.start = 1'b1;
            bus.a     = W'(2);
            bus.b     = W'(2);
         end
         @(posedge clk); #1;
         bus.start = 1'b0;
         check_val("busy_run", 32'(bus.busy), 1);
         if (k < W) begin
            check_val("done_early", 32'(bus.done), 0);
         end else begin
            check_val("done_pulse", 32'(bus.done), 1);
            check_val("product", 32'(bus.product), exp_p);
         end
      end
      @(posedge clk); #1;
      check_val("busy_after", 32'(bus.busy), 0);
      check_val("done_after", 32'(bus.done), 0);
      check_val("product_hold", 32'(bus.product), exp_p);
   endtask

   initial begin
      int unsigned ra, rb;
      int unsigned exp_q[$];
      int unsigned cur;
      int p;

      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      #1;
      check_val("rst_busy", 32'(bus.busy), 0);
      check_val("rst_done", 32'(bus.done), 0);
      check_val("rst_product", 32'(bus.product), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      run_op(3, 5, 0);
      run_op(15, 15, 0);
      run_op(0, 9, 0);
      run_op(9, 0, 0);
      run_op(1, 15, 0);
      run_op(7, 6, 1);

      // Asynchronous reset in the middle of a run.
      bus.start = 1'b1;
      bus.a     = W'(15);
      bus.b     = W'(15);
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_val("arst_busy", 32'(bus.busy), 0);
      check_val("arst_done", 32'(bus.done), 0);
      check_val("arst_product", 32'(bus.product), 0);
      @(posedge clk); #1;
      check_val("arst_hold_busy", 32'(bus.busy), 0);
      rst = 1'b0;
      run_op(2, 3, 0);

      for (int i = 0; i < 20; i++) begin
         ra = $urandom_range(0, 15);
         rb = $urandom_range(0, 15);
         run_op(ra, rb, ($urandom_range(0, 3) == 0));
      end

      // Start held high: accepts every W+2 edges; operands only matter at accepting edges.
      cur = 0;
      bus.start = 1'b1;
      for (int c = 0; c < 256 * (W + 2); c++) begin
         p = c % (W + 2);
         if (p == 0) begin
            bus.a = W'((c / (W + 2)) % 16);
            bus.b = W'((c / (W + 2)) / 16);
            exp_q.push_back(((c / (W + 2)) % 16) * ((c / (W + 2)) / 16));
         end else begin
            bus.a = W'($urandom);
            bus.b = W'($urandom);
         end
         @(posedge clk); #1;
         check_val("sweep_busy", 32'(bus.busy), (p != W + 1) ? 1 : 0);
         check_val("sweep_done", 32'(bus.done), (p == W) ? 1 : 0);
         if (p == W) begin
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            check_val("sweep_product", 32'(bus.product), cur);
         end
      end
      bus.start = 1'b0;
      check_val("sweep_ops_left", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
